gowin_ddr_phase_cal: RTL
========================

GOWIN_DDR_PHASE_CAL -- requirements
Module: gowin_ddr_phase_cal

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 8, number of read-clock phase positions (one step = 45°).
REQ-002 SHALL have parameter STEP_HIGH, default 4, cycles phase_step is held high per step.
REQ-003 SHALL have parameter SETTLE, default 256, cycles waited after each step before sampling.
REQ-004 SHALL have parameter TIMEOUT, default 1024, max cycles waited for sample_valid.
REQ-005 clk  in  1  PLL reference clock, same clock that registers phase_step downstream.
REQ-006 rst_n  in  1  reset; one clock, asynchronous, active-low.
REQ-007 locked  in  1  both DDR PLLs locked.
REQ-008 cal_start  in  1  single-cycle pulse; starts calibration.
REQ-009 sample_valid  in  1  single-cycle pulse; read test result available.
REQ-010 sample_pass  in  1  read test passed; qualified by sample_valid.
REQ-011 phase_step  out  1  step request to the DDR clocking block (rising edge = one step).
REQ-012 phase_updn  out  1  step direction; always 1 (up).
REQ-013 sample_req  out  1  single-cycle pulse; request one read test at current phase.
REQ-014 phase_sel  out  3  tracked current read-clock phase.
REQ-015 pass_map  out  8  per-phase pass bits from last sweep.
REQ-016 win_start / win_len  out  3 / 4  chosen window start and length.
REQ-017 cal_busy / cal_done / cal_fail  out  1 each  status levels.

Function
REQ-018 States: IDLE, WAIT_LOCK, REQ, WAIT_SAMPLE, STEP_HI, STEP_LO, SETTLE, ANALYZE, MOVE, DONE, FAIL.
REQ-019 IDLE/DONE/FAIL -> WAIT_LOCK on cal_start; cal_done, cal_fail cleared, pass_map cleared, sweep index = 0.
REQ-020 WAIT_LOCK -> REQ when locked=1.
REQ-021 REQ: sample_req=1 one cycle -> WAIT_SAMPLE, timeout counter cleared.
REQ-022 WAIT_SAMPLE: on sample_valid, pass_map[phase_sel] <= sample_pass; on TIMEOUT cycles without sample_valid, pass_map[phase_sel] <= 0; then -> STEP_HI.
REQ-023 STEP_HI: phase_step=1 for STEP_HIGH cycles, phase_sel increments mod 8 on entry; then STEP_LO (phase_step=0, 1 cycle) -> SETTLE.
REQ-024 SETTLE: count SETTLE cycles AND require locked=1; then -> REQ if sweep index < 8, else ANALYZE (phase_sel is 0 again after 8 steps).
REQ-025 ANALYZE: find longest circular run of 1s in pass_map; tie -> lowest start; all ones -> start 0, len 8; fixed 16-cycle scan.
REQ-026 ANALYZE result: len 0 -> FAIL; else target = (win_start + win_len/2) mod 8 -> MOVE.
REQ-027 MOVE: issue up-steps (STEP_HI/STEP_LO/SETTLE timing) until phase_sel == target -> DONE; zero steps if already equal.
REQ-028 locked=0 in any state other than IDLE/WAIT_LOCK/DONE/FAIL -> FAIL immediately, phase_step=0.
REQ-029 cal_start while busy SHALL be ignored.
REQ-030 cal_busy=1 in all states except IDLE/DONE/FAIL; cal_done=1 only in DONE; cal_fail=1 only in FAIL.
REQ-031 sample_valid outside WAIT_SAMPLE SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, phase_step=0, phase_updn=1, sample_req=0, phase_sel=0, pass_map=0, win_start=0, win_len=0, all status 0, all counters 0.
REQ-033 phase_sel reset SHALL coincide with the DDR clocking block's phase reset (same reset domain).

Structure
REQ-034 Package gowin_ddr_pkg SHALL hold the state enum and NUM_PHASES/phase-width constants.
REQ-035 Circular-run search SHALL be sub-module gowin_ddr_window_find (pass_map in; start, len, done out).

Verification
REQ-036 pass_map 00111100 -> win_start=2, win_len=4, target 4, exactly 4 MOVE steps, cal_done=1, phase_sel=4.
REQ-037 pass_map 10000011 (wrap) -> win_start=7, win_len=3, target 0, zero MOVE steps, cal_done=1.
REQ-038 pass_map 00110011 (tie) -> win_start=0, win_len=2, target 1, 1 MOVE step.
REQ-039 All samples fail -> cal_fail=1, phase_sel=0, no MOVE steps; all pass -> win_len=8, phase_sel=4.
REQ-040 No sample_valid at phase 3 -> after 1024 cycles bit 3 = 0, sweep continues.
REQ-041 locked dropped during SETTLE of step 5 -> FAIL next cycle, phase_step=0; rst_n low mid-STEP_HI -> all outputs at reset values immediately.

Source files
------------

// File: rtl/gowin_ddr_pkg.sv
// Shared definitions for the Gowin DDR read-clock phase calibrator.
//   - CAL_NUM_PHASES / CAL_PH_W / CAL_LEN_W : phase count and field widths
//   - cal_state_t : calibration FSM state encoding
//   - win_center  : centre phase of a circular pass window
package gowin_ddr_pkg;

  localparam int CAL_NUM_PHASES = 8;
  localparam int CAL_PH_W       = 3;
  localparam int CAL_LEN_W      = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_LOCK,
    ST_REQ,
    ST_WAIT_SAMPLE,
    ST_STEP_HI,
    ST_STEP_LO,
    ST_SETTLE,
    ST_ANALYZE,
    ST_MOVE,
    ST_DONE,
    ST_FAIL
  } cal_state_t;

  // Window centre; the 3-bit sum wraps naturally modulo the phase count.
  function automatic logic [CAL_PH_W-1:0] win_center(
    input logic [CAL_PH_W-1:0]  start,
    input logic [CAL_LEN_W-1:0] len
  );
    return start + len[CAL_PH_W:1];
  endfunction

endpackage

// File: rtl/gowin_ddr_window_find.sv
// Longest circular run of 1s in an 8-bit pass map.
//   clk, rst_n : clock, asynchronous active-low reset
//   go         : one-cycle pulse, starts a scan of pass_map
//   pass_map   : per-phase pass bits (held stable during the scan)
//   start, len : winning run start phase and length (0..8)
//   done       : one-cycle pulse when start/len are valid
// The map is walked twice (16 cycles) so runs that wrap past phase 7 are
// seen whole. Only a strictly longer run replaces the best, so ties keep
// the lowest start; the run length saturates at 8 for an all-ones map.
module gowin_ddr_window_find
  import gowin_ddr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic [7:0]           pass_map,
  output logic [CAL_PH_W-1:0]  start,
  output logic [CAL_LEN_W-1:0] len,
  output logic                 done
);

  logic                 r_busy;
  logic [3:0]           r_i;
  logic [CAL_LEN_W-1:0] r_cur;
  logic [CAL_PH_W-1:0]  r_cstart;
  logic [CAL_LEN_W-1:0] r_best;
  logic [CAL_PH_W-1:0]  r_bstart;
  logic                 r_done;

  logic                 w_bit;
  logic [CAL_LEN_W-1:0] w_cur_nxt;
  logic [CAL_PH_W-1:0]  w_cstart_nxt;

  always_comb begin
    w_bit        = pass_map[r_i[CAL_PH_W-1:0]];
    w_cur_nxt    = '0;
    w_cstart_nxt = r_cstart;
    if (w_bit) begin
      w_cur_nxt = (r_cur == CAL_LEN_W'(CAL_NUM_PHASES)) ? r_cur : r_cur + 1'b1;
      if (r_cur == '0) w_cstart_nxt = r_i[CAL_PH_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_i      <= '0;
      r_cur    <= '0;
      r_cstart <= '0;
      r_best   <= '0;
      r_bstart <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (go) begin
        r_busy   <= 1'b1;
        r_i      <= '0;
        r_cur    <= '0;
        r_cstart <= '0;
        r_best   <= '0;
        r_bstart <= '0;
      end else if (r_busy) begin
        r_cur    <= w_cur_nxt;
        r_cstart <= w_cstart_nxt;
        if (w_cur_nxt > r_best) begin
          r_best   <= w_cur_nxt;
          r_bstart <= w_cstart_nxt;
        end
        r_i <= r_i + 4'd1;
        if (r_i == 4'd15) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign start = r_bstart;
  assign len   = r_best;
  assign done  = r_done;

endmodule

// File: rtl/gowin_ddr_phase_cal.sv
// DDR read-clock phase calibration controller for Gowin DDR PLL clocking.
// Sweeps all read-clock phases, runs one read test per phase, picks the
// centre of the longest circular pass window and steps the clock there.
//   clk, rst_n            : PLL reference clock, async active-low reset
//   locked                : both DDR PLLs locked
//   cal_start             : pulse, starts calibration when not busy
//   sample_valid/_pass    : read test result handshake
//   phase_step/phase_updn : step request / direction to the clocking block
//   sample_req            : pulse, request one read test
//   phase_sel             : tracked current phase
//   pass_map              : per-phase pass bits from the last sweep
//   win_start/win_len     : chosen window
//   cal_busy/done/fail    : status levels
module gowin_ddr_phase_cal
  import gowin_ddr_pkg::*;
#(
  parameter int NUM_PHASES = 8,
  parameter int STEP_HIGH  = 4,
  parameter int SETTLE     = 256,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 locked,
  input  logic                 cal_start,
  input  logic                 sample_valid,
  input  logic                 sample_pass,
  output logic                 phase_step,
  output logic                 phase_updn,
  output logic                 sample_req,
  output logic [CAL_PH_W-1:0]  phase_sel,
  output logic [7:0]           pass_map,
  output logic [CAL_PH_W-1:0]  win_start,
  output logic [CAL_LEN_W-1:0] win_len,
  output logic                 cal_busy,
  output logic                 cal_done,
  output logic                 cal_fail
);

  localparam int CNT_MAX = (TIMEOUT > SETTLE) ?
                           ((TIMEOUT > STEP_HIGH) ? TIMEOUT : STEP_HIGH) :
                           ((SETTLE > STEP_HIGH) ? SETTLE : STEP_HIGH);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  cal_state_t           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [3:0]           r_idx;
  logic                 r_moving;
  logic [CAL_PH_W-1:0]  r_target;
  logic                 r_step;
  logic                 r_req;
  logic [CAL_PH_W-1:0]  r_phase_sel;
  logic [7:0]           r_pass_map;
  logic [CAL_PH_W-1:0]  r_win_start;
  logic [CAL_LEN_W-1:0] r_win_len;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_fail;
  logic                 r_wf_go;

  logic [CAL_PH_W-1:0]  w_wf_start;
  logic [CAL_LEN_W-1:0] w_wf_len;
  logic                 w_wf_done;
  logic                 w_abort;

  gowin_ddr_window_find u_window_find (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (r_wf_go),
    .pass_map (r_pass_map),
    .start    (w_wf_start),
    .len      (w_wf_len),
    .done     (w_wf_done)
  );

  // Losing lock while actively sweeping or moving invalidates the result.
  assign w_abort = !locked && !(r_state inside {ST_IDLE, ST_WAIT_LOCK, ST_DONE, ST_FAIL});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_moving    <= 1'b0;
      r_target    <= '0;
      r_step      <= 1'b0;
      r_req       <= 1'b0;
      r_phase_sel <= '0;
      r_pass_map  <= '0;
      r_win_start <= '0;
      r_win_len   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_wf_go     <= 1'b0;
    end else begin
      r_wf_go <= 1'b0;
      if (w_abort) begin
        r_state  <= ST_FAIL;
        r_step   <= 1'b0;
        r_req    <= 1'b0;
        r_moving <= 1'b0;
        r_busy   <= 1'b0;
        r_fail   <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE, ST_FAIL: begin
            if (cal_start) begin
              r_state    <= ST_WAIT_LOCK;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
              r_fail     <= 1'b0;
              r_pass_map <= '0;
              r_idx      <= '0;
              r_moving   <= 1'b0;
            end
          end
          ST_WAIT_LOCK: begin
            if (locked) begin
              r_state <= ST_REQ;
              r_req   <= 1'b1;
            end
          end
          ST_REQ: begin
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_WAIT_SAMPLE;
          end
          ST_WAIT_SAMPLE: begin
            // A timeout records the phase as failing.
            if (sample_valid || r_cnt == CNT_W'(TIMEOUT - 1)) begin
              r_pass_map[r_phase_sel] <= sample_valid & sample_pass;
              r_idx       <= r_idx + 4'd1;
              r_step      <= 1'b1;
              r_phase_sel <= r_phase_sel + 1'b1;
              r_cnt       <= '0;
              r_state     <= ST_STEP_HI;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_STEP_HI: begin
            if (r_cnt == CNT_W'(STEP_HIGH - 1)) begin
              r_step  <= 1'b0;
              r_state <= ST_STEP_LO;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_STEP_LO: begin
            r_cnt   <= '0;
            r_state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (r_cnt != CNT_W'(SETTLE - 1)) begin
              r_cnt <= r_cnt + 1'b1;
            end else if (locked) begin
              if (r_moving) begin
                r_state <= ST_MOVE;
              end else if (r_idx < 4'(NUM_PHASES)) begin
                r_state <= ST_REQ;
                r_req   <= 1'b1;
              end else begin
                r_state <= ST_ANALYZE;
                r_wf_go <= 1'b1;
              end
            end
          end
          ST_ANALYZE: begin
            if (w_wf_done) begin
              r_win_start <= w_wf_start;
              r_win_len   <= w_wf_len;
              if (w_wf_len == '0) begin
                r_state <= ST_FAIL;
                r_busy  <= 1'b0;
                r_fail  <= 1'b1;
              end else begin
                r_target <= win_center(w_wf_start, w_wf_len);
                r_moving <= 1'b1;
                r_state  <= ST_MOVE;
              end
            end
          end
          ST_MOVE: begin
            if (r_phase_sel == r_target) begin
              r_state  <= ST_DONE;
              r_moving <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_step      <= 1'b1;
              r_phase_sel <= r_phase_sel + 1'b1;
              r_cnt       <= '0;
              r_state     <= ST_STEP_HI;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign phase_step = r_step;
  assign phase_updn = 1'b1;
  assign sample_req = r_req;
  assign phase_sel  = r_phase_sel;
  assign pass_map   = r_pass_map;
  assign win_start  = r_win_start;
  assign win_len    = r_win_len;
  assign cal_busy   = r_busy;
  assign cal_done   = r_done;
  assign cal_fail   = r_fail;

endmodule
